pid_error_calc: RTL and testbench
=================================

Name: pid_error_calc

Overview:
- Stage directly upstream of the PID mixer.
- Takes per-axis setpoints and measured attitude each sample, then computes three terms per axis for pitch, roll and yaw:
  - proportional error,
  - clamped integral,
  - derivative.
- Presents all nine values together and fires a one-cycle cal_pid_en strobe that triggers the mixer's output update.
- A single shared subtract/saturate datapath serves the three axes in sequence.

Parameters:
- I_LIMIT, 16'sd8192, symmetric integrator clamp magnitude (must be 1..32767).
- D_FIRST_ZERO, 1, when 1 the derivative is forced to 0 on the first sample after reset or arming.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- arm  in  1  1 = controller active; 0 = hold integrators and history cleared
- sample_valid  in  1  one-cycle pulse, new setpoint/measurement set present
- sp_pitch, sp_roll, sp_yaw  in  16 signed  setpoints
- meas_pitch, meas_roll, meas_yaw  in  16 signed  measured attitude
- pitch_error, roll_error, yaw_error  out  16 signed  P terms
- i_pitch_error, i_roll_error, i_yaw_error  out  16 signed  integrator states
- d_pitch_error, d_roll_error, d_yaw_error  out  16 signed  derivative terms
- cal_pid_en  out  1  one-cycle strobe, outputs valid and updated
- busy  out  1  high in any state other than IDLE
- sample_drop  out  1  one-cycle pulse, sample_valid arrived while busy

Behaviour:
- Reset (rst=1 at clk edge):
  - all outputs 0;
  - internal integrators, prev_error and first-sample flag cleared;
  - FSM to IDLE.
- Reset mid-operation aborts the sequence: no cal_pid_en, and outputs go to 0.
- FSM states: IDLE, AX_P (pitch), AX_R (roll), AX_Y (yaw), DONE.
  - IDLE: on sample_valid=1, latch all six inputs into registers and go to AX_P.
  - AX_P -> AX_R -> AX_Y -> DONE, then return to IDLE unconditionally. Each transition takes one cycle.
- Latency: sample_valid sampled at edge N. cal_pid_en is high during the cycle after edge N+4, with the nine outputs updated at that same edge. Maximum throughput is one sample per 5 cycles.
- Per-axis step, using the shared datapath:
  - e = sat16(sp - meas), computed 17-bit then saturated to [-32768, 32767].
  - i_new = clamp(i + e, -I_LIMIT, +I_LIMIT), computed 18-bit.
  - d = sat16(e - prev_e). d = 0 when D_FIRST_ZERO=1 and the first-sample flag is set.
  - prev_e <= e.
- Results go to shadow registers. All nine outputs are copied from the shadows at the DONE edge, so the outputs never change mid-sequence and stay stable until the next DONE.
- The first-sample flag is cleared at DONE.
- arm=0:
  - integrators, prev_e and shadows are held at 0, and the first-sample flag is set;
  - P and D are still computed, but i_* outputs are 0 and d_* are 0;
  - cal_pid_en still pulses, so the mixer runs on base throttle.
- arm falling mid-sequence: integrators are zeroed at that edge, and the remaining axes use a 0 integrator.
- sample_valid while busy, including in DONE: the sample is ignored, latched inputs are unchanged, and sample_drop pulses for one cycle.
- sample_valid in the same cycle as rst: rst wins and no capture occurs.
- Integrator clamp is symmetric. When already at +I_LIMIT, a positive e holds it there; a negative e moves it off the limit immediately (no windup).

Decomposition:
- Shared package pid_pkg:
  - AXIS_W = 16;
  - FSM state enum (IDLE, AX_P, AX_R, AX_Y, DONE);
  - axis index constants;
  - sat16 and clamp helper functions.
- One natural sub-module: pid_axis_dp, the combinational per-axis datapath.
  - Inputs: sp, meas, i, prev_e, first, arm.
  - Outputs: e, i_new, d.
  - Instantiated once and muxed by FSM state.

Test Plan:
- Reset then arm=1, sp_pitch=1000, meas_pitch=400, one sample_valid:
  - cal_pid_en 5 cycles later;
  - pitch_error=600, i_pitch_error=600, d_pitch_error=0 (first sample).
- Second sample with meas_pitch=500:
  - pitch_error=500, i_pitch_error=1100, d_pitch_error=-100.
- Saturation: sp_roll=32767, meas_roll=-32768:
  - roll_error=32767.
  - Repeat 3 samples: i_roll_error clamps at 8192.
  - Then sp_roll=meas_roll-100: i_roll_error=8092.
- sample_valid pulsed 2 cycles after an accepted sample:
  - sample_drop=1 for one cycle;
  - exactly one cal_pid_en;
  - outputs reflect the first sample only.
- arm dropped after integrators reach 3000:
  - next sample gives i_*=0 and d_*=0, with P terms still correct.
  - Re-arm: first D is 0 again.
- rst asserted in AX_R: no cal_pid_en, all outputs 0 next cycle, FSM in IDLE.

Source files
------------

// File: rtl/pid_pkg.sv
// pid_pkg: shared width, FSM states, axis indices and saturating helpers for pid_error_calc
package pid_pkg;
  localparam int AXIS_W = 16;
  localparam logic [1:0] AX_PITCH = 2'd0;
  localparam logic [1:0] AX_ROLL  = 2'd1;
  localparam logic [1:0] AX_YAW   = 2'd2;
  typedef enum logic [2:0] {IDLE, AX_P, AX_R, AX_Y, DONE} state_t;
  function automatic logic signed [AXIS_W-1:0] sat16(input logic signed [AXIS_W+1:0] x);
    return x > 18'sd32767 ? 16'sh7fff : x < -18'sd32768 ? 16'sh8000 : x[AXIS_W-1:0];
  endfunction
  function automatic logic signed [AXIS_W-1:0] clamp(input logic signed [AXIS_W+1:0] x,
                                                     input logic signed [AXIS_W-1:0] lim);
    logic signed [AXIS_W+1:0] l;
    l = (AXIS_W+2)'(lim);
    return x > l ? lim : x < -l ? -lim : x[AXIS_W-1:0];
  endfunction
endpackage

// File: rtl/pid_axis_dp.sv
// pid_axis_dp: combinational per-axis P/I/D step shared by all three axes
//   in : sp, meas (latched setpoint/measurement), i (integrator), prev_e, first, arm
//   out: e (P term), i_new (clamped integrator), d (derivative)
module pid_axis_dp import pid_pkg::*; #(
  parameter logic signed [AXIS_W-1:0] I_LIMIT      = 16'sd8192,
  parameter bit                       D_FIRST_ZERO = 1'b1
) (
  input  logic signed [AXIS_W-1:0] sp,
  input  logic signed [AXIS_W-1:0] meas,
  input  logic signed [AXIS_W-1:0] i,
  input  logic signed [AXIS_W-1:0] prev_e,
  input  logic                     first,
  input  logic                     arm,
  output logic signed [AXIS_W-1:0] e,
  output logic signed [AXIS_W-1:0] i_new,
  output logic signed [AXIS_W-1:0] d
);
  always_comb begin
    e = sat16((AXIS_W+2)'(sp) - (AXIS_W+2)'(meas));
    i_new = arm ? clamp((AXIS_W+2)'(i) + (AXIS_W+2)'(e), I_LIMIT) : '0;
    d = (!arm || (D_FIRST_ZERO && first)) ? '0 : sat16((AXIS_W+2)'(e) - (AXIS_W+2)'(prev_e));
  end
endmodule

// File: rtl/pid_error_calc.sv
// pid_error_calc: sequences pitch/roll/yaw through one shared P/I/D datapath and strobes cal_pid_en
//   in : clk, rst, arm, sample_valid, sp_* / meas_* (signed setpoints and attitude)
//   out: *_error (P), i_*_error (integrators), d_*_error (derivatives), cal_pid_en, busy, sample_drop
module pid_error_calc import pid_pkg::*; #(
  parameter logic signed [AXIS_W-1:0] I_LIMIT      = 16'sd8192,
  parameter bit                       D_FIRST_ZERO = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     sample_valid,
  input  logic signed [AXIS_W-1:0] sp_pitch,
  input  logic signed [AXIS_W-1:0] sp_roll,
  input  logic signed [AXIS_W-1:0] sp_yaw,
  input  logic signed [AXIS_W-1:0] meas_pitch,
  input  logic signed [AXIS_W-1:0] meas_roll,
  input  logic signed [AXIS_W-1:0] meas_yaw,
  output logic signed [AXIS_W-1:0] pitch_error,
  output logic signed [AXIS_W-1:0] roll_error,
  output logic signed [AXIS_W-1:0] yaw_error,
  output logic signed [AXIS_W-1:0] i_pitch_error,
  output logic signed [AXIS_W-1:0] i_roll_error,
  output logic signed [AXIS_W-1:0] i_yaw_error,
  output logic signed [AXIS_W-1:0] d_pitch_error,
  output logic signed [AXIS_W-1:0] d_roll_error,
  output logic signed [AXIS_W-1:0] d_yaw_error,
  output logic                     cal_pid_en,
  output logic                     busy,
  output logic                     sample_drop
);
  typedef logic signed [AXIS_W-1:0] word_t;
  state_t state_q, state_d;
  word_t sp_q [3], sp_d [3], meas_q [3], meas_d [3];
  word_t integ_q [3], integ_d [3], prev_q [3], prev_d [3];
  word_t ps_q [3], ps_d [3], is_q [3], is_d [3], ds_q [3], ds_d [3];
  word_t p_q [3], p_d [3], i_q [3], i_d [3], d_q [3], d_d [3];
  logic first_q, first_d, cal_q, cal_d, drop_q, drop_d;
  logic [1:0] ax;
  word_t e, i_new, d;
  always_comb ax = state_q == AX_R ? AX_ROLL : state_q == AX_Y ? AX_YAW : AX_PITCH;
  pid_axis_dp #(.I_LIMIT(I_LIMIT), .D_FIRST_ZERO(D_FIRST_ZERO)) u_dp (
    .sp(sp_q[ax]), .meas(meas_q[ax]), .i(integ_q[ax]), .prev_e(prev_q[ax]),
    .first(first_q), .arm(arm), .e(e), .i_new(i_new), .d(d)
  );
  always_comb begin
    state_d = state_q;
    sp_d = sp_q;
    meas_d = meas_q;
    integ_d = integ_q;
    prev_d = prev_q;
    ps_d = ps_q;
    is_d = is_q;
    ds_d = ds_q;
    p_d = p_q;
    i_d = i_q;
    d_d = d_q;
    first_d = first_q;
    cal_d = 1'b0;
    drop_d = sample_valid && state_q != IDLE;
    case (state_q)
      IDLE: if (sample_valid) begin
        state_d = AX_P;
        sp_d = '{sp_pitch, sp_roll, sp_yaw};
        meas_d = '{meas_pitch, meas_roll, meas_yaw};
      end
      AX_P, AX_R, AX_Y: begin
        state_d = state_q == AX_P ? AX_R : state_q == AX_R ? AX_Y : DONE;
        integ_d[ax] = i_new;
        prev_d[ax] = e;
        ps_d[ax] = e;
        is_d[ax] = i_new;
        ds_d[ax] = d;
      end
      DONE: begin
        state_d = IDLE;
        p_d = ps_q;
        i_d = is_q;
        d_d = ds_q;
        cal_d = 1'b1;
        first_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Disarmed: wipe controller memory; an arm drop landing on DONE must not publish stale I/D.
    if (!arm) begin
      first_d = 1'b1;
      for (int k = 0; k < 3; k++) begin
        integ_d[k] = '0;
        prev_d[k] = '0;
        is_d[k] = '0;
        ds_d[k] = '0;
        if (state_q == DONE) begin
          i_d[k] = '0;
          d_d[k] = '0;
        end
      end
    end
  end
  // Reset leaves the first-sample flag set so the first derivative after reset is suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      first_q <= 1'b1;
      cal_q <= 1'b0;
      drop_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        sp_q[k] <= '0;
        meas_q[k] <= '0;
        integ_q[k] <= '0;
        prev_q[k] <= '0;
        ps_q[k] <= '0;
        is_q[k] <= '0;
        ds_q[k] <= '0;
        p_q[k] <= '0;
        i_q[k] <= '0;
        d_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      cal_q <= cal_d;
      drop_q <= drop_d;
      sp_q <= sp_d;
      meas_q <= meas_d;
      integ_q <= integ_d;
      prev_q <= prev_d;
      ps_q <= ps_d;
      is_q <= is_d;
      ds_q <= ds_d;
      p_q <= p_d;
      i_q <= i_d;
      d_q <= d_d;
    end
  end
  assign pitch_error = p_q[AX_PITCH];
  assign roll_error = p_q[AX_ROLL];
  assign yaw_error = p_q[AX_YAW];
  assign i_pitch_error = i_q[AX_PITCH];
  assign i_roll_error = i_q[AX_ROLL];
  assign i_yaw_error = i_q[AX_YAW];
  assign d_pitch_error = d_q[AX_PITCH];
  assign d_roll_error = d_q[AX_ROLL];
  assign d_yaw_error = d_q[AX_YAW];
  assign cal_pid_en = cal_q;
  assign sample_drop = drop_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_pid_error_calc.sv
// tb_pid_error_calc: randomized and directed checks of pid_error_calc against a per-sample arithmetic model
module tb_pid_error_calc;
  localparam int LIM = 8192;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b1;
  logic sample_valid = 1'b0;
  logic signed [15:0] sp [3], meas [3], pe [3], ie [3], de [3];
  logic cal_pid_en, busy, sample_drop;
  int n_vec = 0;
  int n_err = 0;
  int tsp [3], tmeas [3], m_i [3], m_prev [3], x_p [3], x_i [3], x_d [3];
  bit m_first = 1'b1;
  always #5 clk = ~clk;
  pid_error_calc dut (
    .clk(clk), .rst(rst), .arm(arm), .sample_valid(sample_valid),
    .sp_pitch(sp[0]), .sp_roll(sp[1]), .sp_yaw(sp[2]),
    .meas_pitch(meas[0]), .meas_roll(meas[1]), .meas_yaw(meas[2]),
    .pitch_error(pe[0]), .roll_error(pe[1]), .yaw_error(pe[2]),
    .i_pitch_error(ie[0]), .i_roll_error(ie[1]), .i_yaw_error(ie[2]),
    .d_pitch_error(de[0]), .d_roll_error(de[1]), .d_yaw_error(de[2]),
    .cal_pid_en(cal_pid_en), .busy(busy), .sample_drop(sample_drop)
  );
  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask
  function automatic int sat(input int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction
  function automatic int lim(input int v);
    return v > LIM ? LIM : v < -LIM ? -LIM : v;
  endfunction
  function automatic int rnd();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 1) ? 32767 : -32768;
      1: return int'($urandom_range(0, 600)) - 300;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction
  task automatic model_clear();
    for (int a = 0; a < 3; a++) begin
      m_i[a] = 0;
      m_prev[a] = 0;
    end
    m_first = 1'b1;
  endtask
  task automatic model_step();
    for (int a = 0; a < 3; a++) begin
      int e;
      e = sat(tsp[a] - tmeas[a]);
      x_p[a] = e;
      if (arm) begin
        m_i[a] = lim(m_i[a] + e);
        x_i[a] = m_i[a];
        x_d[a] = m_first ? 0 : sat(e - m_prev[a]);
        m_prev[a] = e;
      end else begin
        m_i[a] = 0;
        m_prev[a] = 0;
        x_i[a] = 0;
        x_d[a] = 0;
      end
    end
    m_first = !arm;
  endtask
  task automatic run(input bit inj);
    int cyc, lat, ncal, ndrop;
    model_step();
    @(negedge clk);
    for (int a = 0; a < 3; a++) begin
      sp[a] = 16'(tsp[a]);
      meas[a] = 16'(tmeas[a]);
    end
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    cyc = 1;
    lat = 0;
    ncal = 0;
    ndrop = 0;
    chk("busy", busy, 1);
    repeat (9) begin
      if (inj && cyc == 2) begin
        for (int a = 0; a < 3; a++) begin
          sp[a] = 16'($urandom);
          meas[a] = 16'($urandom);
        end
        sample_valid = 1'b1;
      end
      @(negedge clk);
      sample_valid = 1'b0;
      cyc++;
      if (sample_drop) ndrop++;
      if (cal_pid_en) begin
        ncal++;
        if (lat == 0) begin
          lat = cyc;
          for (int a = 0; a < 3; a++) begin
            chk($sformatf("p%0d", a), pe[a], x_p[a]);
            chk($sformatf("i%0d", a), ie[a], x_i[a]);
            chk($sformatf("d%0d", a), de[a], x_d[a]);
          end
        end
      end
    end
    chk("latency", lat, 5);
    chk("ncal", ncal, 1);
    chk("ndrop", ndrop, inj ? 1 : 0);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int ncal;
    for (int a = 0; a < 3; a++) begin
      sp[a] = '0;
      meas[a] = '0;
      tsp[a] = 0;
      tmeas[a] = 0;
    end
    repeat (3) @(negedge clk);
    for (int a = 0; a < 3; a++) begin
      chk("rst_p", pe[a], 0);
      chk("rst_i", ie[a], 0);
      chk("rst_d", de[a], 0);
    end
    chk("rst_cal", cal_pid_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", sample_drop, 0);
    rst = 1'b0;
    tsp[0] = 1000;
    tmeas[0] = 400;
    run(1'b0);
    chk("tp1_p", pe[0], 600);
    chk("tp1_i", ie[0], 600);
    chk("tp1_d", de[0], 0);
    tmeas[0] = 500;
    run(1'b0);
    chk("tp2_p", pe[0], 500);
    chk("tp2_i", ie[0], 1100);
    chk("tp2_d", de[0], -100);
    tsp[1] = 32767;
    tmeas[1] = -32768;
    repeat (3) run(1'b0);
    chk("sat_p", pe[1], 32767);
    chk("sat_i", ie[1], 8192);
    tsp[1] = 900;
    tmeas[1] = 1000;
    run(1'b0);
    chk("unwind_i", ie[1], 8092);
    run(1'b1);
    arm = 1'b0;
    model_clear();
    @(negedge clk);
    arm = 1'b1;
    for (int a = 0; a < 3; a++) begin
      tsp[a] = 1000;
      tmeas[a] = 0;
    end
    repeat (3) run(1'b0);
    chk("i3000", ie[0], 3000);
    arm = 1'b0;
    model_clear();
    run(1'b0);
    for (int a = 0; a < 3; a++) begin
      chk("disarm_p", pe[a], 1000);
      chk("disarm_i", ie[a], 0);
      chk("disarm_d", de[a], 0);
    end
    arm = 1'b1;
    for (int a = 0; a < 3; a++) tmeas[a] = 200;
    run(1'b0);
    chk("rearm_d", de[0], 0);
    chk("rearm_i", ie[0], 800);
    @(negedge clk);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int a = 0; a < 3; a++) begin
      chk("abort_p", pe[a], 0);
      chk("abort_i", ie[a], 0);
      chk("abort_d", de[a], 0);
    end
    chk("abort_busy", busy, 0);
    ncal = int'(cal_pid_en);
    repeat (8) begin
      @(negedge clk);
      if (cal_pid_en) ncal++;
    end
    chk("abort_ncal", ncal, 0);
    rst = 1'b1;
    sample_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sample_valid = 1'b0;
    chk("rst_sv_busy", busy, 0);
    @(negedge clk);
    chk("rst_sv_busy2", busy, 0);
    repeat (150) begin
      if ($urandom_range(0, 9) == 0) begin
        arm = ~arm;
        if (!arm) model_clear();
        @(negedge clk);
      end
      for (int a = 0; a < 3; a++) begin
        tsp[a] = rnd();
        tmeas[a] = rnd();
      end
      run($urandom_range(0, 7) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
